// File: rtl/weight_loader_pkg.sv
// Shared constants and elaboration helpers for the weight loader.
package weight_loader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic MODE_SEQ   = 1'b0;
  localparam logic MODE_BCAST = 1'b1;

  // Number of bits needed to hold value (minimum 1).
  function automatic int clogb2(input int value);
    int n;
    n = 1;
    for (int i = 0; i < 31; i++) begin
      if (value >= (1 << i)) n = i + 1;
    end
    return n;
  endfunction

  function automatic int beat_width(input int data_len, input int lanes);
    return data_len * lanes;
  endfunction

  function automatic int group_count(input int buffer_num, input int lanes);
    return buffer_num / lanes;
  endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// Tap/weight/group counters producing the bank address and group of the beat being written.
module weight_addr_gen
  import weight_loader_pkg::*;
#(
  parameter int ADDR_LEN   = 16,
  parameter int SINGLE_LEN = 24,
  parameter int TAP_W      = 4,
  parameter int GRP_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_LEN-1:0]   base,
  input  logic [TAP_W-1:0]      taps,
  input  logic [SINGLE_LEN-1:0] wnum,
  input  logic [GRP_W-1:0]      last_group,
  output logic [ADDR_LEN-1:0]   addr,
  output logic [GRP_W-1:0]      group,
  output logic                  last
);

  logic [ADDR_LEN-1:0]   base_r;
  logic [TAP_W-1:0]      taps_r;
  logic [SINGLE_LEN-1:0] wnum_r;
  logic [GRP_W-1:0]      last_group_r;
  logic [TAP_W-1:0]      tap_cnt;
  logic [SINGLE_LEN-1:0] w_cnt;
  logic                  tap_end;
  logic                  w_end;

  assign tap_end = (tap_cnt == taps_r - TAP_W'(1));
  assign w_end   = (w_cnt == wnum_r - SINGLE_LEN'(1));
  assign last    = tap_end && w_end && (group == last_group_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r       <= '0;
      taps_r       <= '0;
      wnum_r       <= '0;
      last_group_r <= '0;
      tap_cnt      <= '0;
      w_cnt        <= '0;
      group        <= '0;
      addr         <= '0;
    end else if (load) begin
      base_r       <= base;
      taps_r       <= taps;
      wnum_r       <= wnum;
      last_group_r <= last_group;
      tap_cnt      <= '0;
      w_cnt        <= '0;
      group        <= '0;
      addr         <= base;
    end else if (step) begin
      // Each group restarts at the base address; addresses wrap naturally.
      if (tap_end && w_end) begin
        tap_cnt <= '0;
        w_cnt   <= '0;
        group   <= group + GRP_W'(1);
        addr    <= base_r;
      end else begin
        addr <= addr + ADDR_LEN'(1);
        if (tap_end) begin
          tap_cnt <= '0;
          w_cnt   <= w_cnt + SINGLE_LEN'(1);
        end else begin
          tap_cnt <= tap_cnt + TAP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streams convolution weights from the DDR read FIFO into the weight-buffer bank array.
// One-cycle write latency per popped beat; pops only while the FIFO is non-empty.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_LEN     = 64,
  parameter int LANES        = 8,
  parameter int BUFFER_NUM   = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int MAX_TAPS     = 9,
  localparam int TAP_W       = clogb2(MAX_TAPS),
  localparam int BEAT_W      = beat_width(DATA_LEN, LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    conf,
  input  logic                    mode,
  input  logic [TAP_W-1:0]        taps,
  input  logic [SINGLE_LEN-1:0]   weight_num,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
  input  logic [ADDR_LEN-1:0]     wb_st_addr,
  input  logic                    abort,
  output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]   ddr_len,
  output logic                    ddr_conf,
  input  logic                    ddr_fifo_empty,
  output logic                    ddr_fifo_req,
  input  logic [BEAT_W-1:0]       ddr_fifo_data,
  output logic [ADDR_LEN-1:0]     wb_addr,
  output logic [BEAT_W-1:0]       wb_data,
  output logic [BUFFER_NUM-1:0]   wb_wea,
  output logic                    idle,
  output logic                    done,
  output logic                    conf_err
);

  localparam int GROUPS = group_count(BUFFER_NUM, LANES);
  localparam int GRP_W  = clogb2(GROUPS);
  localparam int CNT_W  = SINGLE_LEN + TAP_W + GRP_W;

  logic [1:0]            state;
  logic                  mode_r;
  logic [CNT_W-1:0]      total_r;
  logic [CNT_W-1:0]      issued;
  logic [CNT_W-1:0]      total_n;
  logic                  wr_vld;
  logic                  wr;
  logic                  fields_ok;
  logic                  start;
  logic [GRP_W-1:0]      group;
  logic                  last_beat;
  logic [BUFFER_NUM-1:0] grp_mask;

  assign fields_ok = (taps != '0) && (int'(taps) <= MAX_TAPS) && (weight_num != '0);
  assign start     = (state == ST_IDLE) && conf && fields_ok;
  assign idle      = (state == ST_IDLE);

  always_comb begin
    total_n = CNT_W'(weight_num) * CNT_W'(taps);
    if (mode == MODE_SEQ) total_n = total_n * CNT_W'(GROUPS);
  end

  assign ddr_fifo_req = (state == ST_RUN) && !ddr_fifo_empty && (issued < total_r) && !abort;

  // The beat popped last cycle is on the FIFO output now; abort discards it.
  assign wr = wr_vld && !abort;

  always_comb begin
    grp_mask = '1;
    if (mode_r == MODE_SEQ) grp_mask = BUFFER_NUM'({LANES{1'b1}}) << (int'(group) * LANES);
  end

  assign wb_wea  = wr ? grp_mask : '0;
  assign wb_data = wr ? ddr_fifo_data : '0;

  weight_addr_gen #(
    .ADDR_LEN  (ADDR_LEN),
    .SINGLE_LEN(SINGLE_LEN),
    .TAP_W     (TAP_W),
    .GRP_W     (GRP_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (start),
    .step      (wr),
    .base      (wb_st_addr),
    .taps      (taps),
    .wnum      (weight_num),
    .last_group((mode == MODE_BCAST) ? GRP_W'(0) : GRP_W'(GROUPS - 1)),
    .addr      (wb_addr),
    .group     (group),
    .last      (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      mode_r          <= MODE_SEQ;
      total_r         <= '0;
      issued          <= '0;
      wr_vld          <= 1'b0;
      ddr_conf        <= 1'b0;
      ddr_len         <= '0;
      ddr_st_addr_out <= '0;
      done            <= 1'b0;
      conf_err        <= 1'b0;
    end else begin
      ddr_conf <= 1'b0;
      done     <= 1'b0;
      conf_err <= conf && !start;
      wr_vld   <= ddr_fifo_req;
      if (ddr_fifo_req) issued <= issued + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state           <= ST_RUN;
            mode_r          <= mode;
            total_r         <= total_n;
            issued          <= '0;
            ddr_conf        <= 1'b1;
            ddr_st_addr_out <= ddr_st_addr;
            ddr_len         <= SINGLE_LEN'(total_n * CNT_W'(BEAT_W / 8));
          end
        end
        ST_RUN: begin
          if (abort) state <= ST_IDLE;
          else if (ddr_fifo_req && (issued == total_r - CNT_W'(1))) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (wr && last_beat) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: sequential, broadcast, FIFO gaps, config errors, abort, wrap, reset.
module tb_weight_loader;

  localparam int DATA_LEN = 64, LANES = 8, BUFFER_NUM = 32, ADDR_LEN = 16;
  localparam int DDR_ADDR_LEN = 32, SINGLE_LEN = 24, MAX_TAPS = 9, TAP_W = 4;
  localparam int BEAT_W = DATA_LEN * LANES;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    conf = 1'b0;
  logic                    mode = 1'b0;
  logic [TAP_W-1:0]        taps = '0;
  logic [SINGLE_LEN-1:0]   weight_num = '0;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr = '0;
  logic [ADDR_LEN-1:0]     wb_st_addr = '0;
  logic                    abort = 1'b0;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic                    ddr_fifo_empty = 1'b0;
  logic                    ddr_fifo_req;
  logic [BEAT_W-1:0]       ddr_fifo_data = '0;
  logic [ADDR_LEN-1:0]     wb_addr;
  logic [BEAT_W-1:0]       wb_data;
  logic [BUFFER_NUM-1:0]   wb_wea;
  logic                    idle;
  logic                    done;
  logic                    conf_err;

  int checks = 0;
  int errors = 0;
  int pops = 0;

  // Observations gathered by run_job for the scenario tasks to judge.
  logic [ADDR_LEN-1:0]   w_addr[$];
  logic [BUFFER_NUM-1:0] w_wea[$];
  logic [BEAT_W-1:0]     w_data[$];
  int n_conf, conf_cyc, done_cnt, done_cyc, idle_cyc, err_cnt, abort_cyc;
  int req_empty_viol, bubble_viol, done_idle_bad, timeout, pops_start;
  logic [SINGLE_LEN-1:0]   len_seen;
  logic [DDR_ADDR_LEN-1:0] addr_seen;

  weight_loader dut (
    .clk(clk), .rst(rst), .conf(conf), .mode(mode), .taps(taps), .weight_num(weight_num),
    .ddr_st_addr(ddr_st_addr), .wb_st_addr(wb_st_addr), .abort(abort),
    .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len), .ddr_conf(ddr_conf),
    .ddr_fifo_empty(ddr_fifo_empty), .ddr_fifo_req(ddr_fifo_req), .ddr_fifo_data(ddr_fifo_data),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_wea(wb_wea), .idle(idle), .done(done),
    .conf_err(conf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [BEAT_W-1:0] beat_val(input int n);
    logic [BEAT_W-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) v[k*DATA_LEN +: DATA_LEN] = {32'hB000_0000 + 32'(n), 32'(k)};
    return v;
  endfunction

  // Registered-read FIFO: a pop in cycle n presents its beat in cycle n+1.
  always @(posedge clk) begin
    if (ddr_fifo_req) begin
      ddr_fifo_data <= beat_val(pops);
      pops <= pops + 1;
    end
  end

  task automatic run_job(input logic m, input logic [TAP_W-1:0] tp, input logic [SINGLE_LEN-1:0] wn,
                         input logic [DDR_ADDR_LEN-1:0] da, input logic [ADDR_LEN-1:0] ba,
                         input bit gaps, input int abort_after, input int max_cyc);
    bit finished;
    bit prev_req;
    bit exp_wr;
    w_addr.delete(); w_wea.delete(); w_data.delete();
    n_conf = 0; conf_cyc = -1; done_cnt = 0; done_cyc = -1; idle_cyc = -1; err_cnt = 0;
    abort_cyc = -1; req_empty_viol = 0; bubble_viol = 0; done_idle_bad = 0; timeout = 0;
    len_seen = '0; addr_seen = '0; finished = 0; prev_req = 0;
    @(posedge clk); #1;
    pops_start = pops;
    conf = 1'b1; mode = m; taps = tp; weight_num = wn; ddr_st_addr = da; wb_st_addr = ba;
    ddr_fifo_empty = 1'b0;
    for (int cyc = 1; cyc <= max_cyc && !finished; cyc++) begin
      @(posedge clk); #1;
      conf = 1'b0;
      abort = 1'b0;
      if (abort_after >= 0 && abort_cyc < 0 && w_addr.size() == abort_after) begin
        abort = 1'b1;
        conf = 1'b1;
        abort_cyc = cyc;
      end
      ddr_fifo_empty = gaps ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
      if (ddr_fifo_req && ddr_fifo_empty) req_empty_viol++;
      exp_wr = prev_req && !abort;
      if ((wb_wea != '0) != exp_wr) bubble_viol++;
      if (wb_wea != '0) begin
        w_addr.push_back(wb_addr);
        w_wea.push_back(wb_wea);
        w_data.push_back(wb_data);
      end
      if (ddr_conf) begin
        n_conf++; conf_cyc = cyc; len_seen = ddr_len; addr_seen = ddr_st_addr_out;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        if (!idle) done_idle_bad++;
      end
      if (conf_err) err_cnt++;
      if (idle && idle_cyc < 0) idle_cyc = cyc;
      prev_req = ddr_fifo_req;
      if (done_cnt > 0 && cyc >= done_cyc + 3) finished = 1;
      if (abort_cyc > 0 && cyc >= abort_cyc + 4) finished = 1;
    end
    if (!finished) timeout = 1;
    conf = 1'b0; abort = 1'b0; ddr_fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++;
    if ({ddr_conf, ddr_fifo_req, done, conf_err} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {ddr_conf, ddr_fifo_req, done, conf_err});
    end
    checks++;
    if (wb_wea !== '0 || wb_addr !== '0 || wb_data !== '0) begin
      errors++; $display("FAIL reset_wb: got wea %h addr %h expected 0", wb_wea, wb_addr);
    end
    checks++;
    if (ddr_len !== '0 || ddr_st_addr_out !== '0) begin
      errors++; $display("FAIL reset_ddr: got len %0d addr %h expected 0", ddr_len, ddr_st_addr_out);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [ADDR_LEN-1:0] ea;
    logic [BUFFER_NUM-1:0] ew;
    run_job(1'b0, 4'd9, 24'd2, 32'h8000_1000, 16'h0010, 1'b0, -1, 200);
    checks++;
    if (timeout != 0) begin errors++; $display("FAIL seq_timeout: got timeout expected done"); end
    checks++;
    if (n_conf != 1 || conf_cyc != 1) begin
      errors++; $display("FAIL seq_ddr_conf: got %0d pulses at cycle %0d expected 1 at 1", n_conf, conf_cyc);
    end
    checks++;
    if (len_seen !== 24'd4608) begin errors++; $display("FAIL seq_ddr_len: got %0d expected 4608", len_seen); end
    checks++;
    if (addr_seen !== 32'h8000_1000) begin errors++; $display("FAIL seq_ddr_addr: got %h expected 80001000", addr_seen); end
    checks++;
    if (w_addr.size() != 72) begin errors++; $display("FAIL seq_count: got %0d expected 72", w_addr.size()); end
    for (int k = 0; k < w_addr.size() && k < 72; k++) begin
      ea = 16'h0010 + 16'(k % 18);
      ew = 32'h0000_00FF << (8 * (k / 18));
      checks++;
      if (w_addr[k] !== ea || w_wea[k] !== ew || w_data[k] !== beat_val(pops_start + k)) begin
        errors++; $display("FAIL seq_write%0d: got addr %h wea %h expected addr %h wea %h", k, w_addr[k], w_wea[k], ea, ew);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 74) begin
      errors++; $display("FAIL seq_done: got %0d pulses at cycle %0d expected 1 at 74", done_cnt, done_cyc);
    end
    checks++;
    if (done_idle_bad != 0 || bubble_viol != 0) begin
      errors++; $display("FAIL seq_timing: got %0d done/idle and %0d wea faults expected 0", done_idle_bad, bubble_viol);
    end
  endtask

  task automatic test_broadcast();
    run_job(1'b1, 4'd1, 24'd5, 32'h0000_2000, 16'h0010, 1'b0, -1, 100);
    checks++;
    if (timeout != 0 || len_seen !== 24'd320) begin
      errors++; $display("FAIL bc_len: got %0d (timeout %0d) expected 320", len_seen, timeout);
    end
    checks++;
    if (w_addr.size() != 5) begin errors++; $display("FAIL bc_count: got %0d expected 5", w_addr.size()); end
    for (int k = 0; k < w_addr.size() && k < 5; k++) begin
      checks++;
      if (w_addr[k] !== 16'h0010 + 16'(k) || w_wea[k] !== 32'hFFFF_FFFF || w_data[k] !== beat_val(pops_start + k)) begin
        errors++; $display("FAIL bc_write%0d: got addr %h wea %h expected addr %h wea ffffffff", k, w_addr[k], w_wea[k], 16'h0010 + 16'(k));
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 7) begin
      errors++; $display("FAIL bc_done: got %0d pulses at cycle %0d expected 1 at 7", done_cnt, done_cyc);
    end
  endtask

  task automatic test_fifo_gaps();
    logic [ADDR_LEN-1:0] ea;
    logic [BUFFER_NUM-1:0] ew;
    run_job(1'b0, 4'd3, 24'd2, 32'h0000_4000, 16'h0040, 1'b1, -1, 400);
    checks++;
    if (timeout != 0 || len_seen !== 24'd1536) begin
      errors++; $display("FAIL gap_len: got %0d (timeout %0d) expected 1536", len_seen, timeout);
    end
    checks++;
    if (req_empty_viol != 0) begin errors++; $display("FAIL gap_req_empty: got %0d expected 0", req_empty_viol); end
    checks++;
    if (bubble_viol != 0) begin errors++; $display("FAIL gap_bubble: got %0d expected 0", bubble_viol); end
    checks++;
    if (pops - pops_start != 24) begin errors++; $display("FAIL gap_pops: got %0d expected 24", pops - pops_start); end
    checks++;
    if (w_addr.size() != 24) begin errors++; $display("FAIL gap_count: got %0d expected 24", w_addr.size()); end
    for (int k = 0; k < w_addr.size() && k < 24; k++) begin
      ea = 16'h0040 + 16'(k % 6);
      ew = 32'h0000_00FF << (8 * (k / 6));
      checks++;
      if (w_addr[k] !== ea || w_wea[k] !== ew || w_data[k] !== beat_val(pops_start + k)) begin
        errors++; $display("FAIL gap_write%0d: got addr %h wea %h expected addr %h wea %h", k, w_addr[k], w_wea[k], ea, ew);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL gap_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_conf_err();
    logic [TAP_W-1:0]      bad_taps[3] = '{4'd0, 4'd10, 4'd3};
    logic [SINGLE_LEN-1:0] bad_wnum[3] = '{24'd2, 24'd2, 24'd0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      conf = 1'b1; mode = 1'b0; taps = bad_taps[i]; weight_num = bad_wnum[i];
      @(posedge clk); #1 conf = 1'b0;
      @(negedge clk);
      checks++;
      if (conf_err !== 1'b1 || idle !== 1'b1 || ddr_conf !== 1'b0) begin
        errors++; $display("FAIL conf_err%0d: got err %b idle %b ddr_conf %b expected 1 1 0", i, conf_err, idle, ddr_conf);
      end
      @(negedge clk);
      checks++;
      if (conf_err !== 1'b0 || idle !== 1'b1 || ddr_conf !== 1'b0 || ddr_fifo_req !== 1'b0) begin
        errors++; $display("FAIL conf_err_after%0d: got err %b idle %b ddr_conf %b expected 0 1 0", i, conf_err, idle, ddr_conf);
      end
    end
  endtask

  task automatic test_abort();
    run_job(1'b0, 4'd3, 24'd2, 32'h0000_6000, 16'h0040, 1'b0, 7, 200);
    checks++;
    if (timeout != 0 || abort_cyc != 9) begin
      errors++; $display("FAIL abort_cycle: got %0d (timeout %0d) expected 9", abort_cyc, timeout);
    end
    checks++;
    if (w_addr.size() != 7) begin errors++; $display("FAIL abort_writes: got %0d expected 7", w_addr.size()); end
    checks++;
    if (w_addr.size() == 7 && (w_addr[6] !== 16'h0040 || w_wea[6] !== 32'h0000_FF00)) begin
      errors++; $display("FAIL abort_last_write: got addr %h wea %h expected 0040 0000ff00", w_addr[6], w_wea[6]);
    end
    checks++;
    if (pops - pops_start != 8) begin errors++; $display("FAIL abort_pops: got %0d expected 8", pops - pops_start); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    checks++;
    if (idle_cyc != abort_cyc + 1) begin errors++; $display("FAIL abort_idle: got %0d expected %0d", idle_cyc, abort_cyc + 1); end
    checks++;
    if (err_cnt != 1) begin errors++; $display("FAIL abort_conf_err: got %0d expected 1", err_cnt); end
    // A fresh job after the abort must run from a clean start.
    run_job(1'b1, 4'd2, 24'd3, 32'h0000_7000, 16'h0020, 1'b0, -1, 100);
    checks++;
    if (timeout != 0 || len_seen !== 24'd384 || w_addr.size() != 6) begin
      errors++; $display("FAIL rerun_shape: got len %0d writes %0d expected 384 6", len_seen, w_addr.size());
    end
    for (int k = 0; k < w_addr.size() && k < 6; k++) begin
      checks++;
      if (w_addr[k] !== 16'h0020 + 16'(k) || w_wea[k] !== 32'hFFFF_FFFF || w_data[k] !== beat_val(pops_start + k)) begin
        errors++; $display("FAIL rerun_write%0d: got addr %h wea %h expected addr %h", k, w_addr[k], w_wea[k], 16'h0020 + 16'(k));
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 8) begin
      errors++; $display("FAIL rerun_done: got %0d at cycle %0d expected 1 at 8", done_cnt, done_cyc);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [ADDR_LEN-1:0] exp_wrap[6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    run_job(1'b1, 4'd3, 24'd2, 32'h0000_8000, 16'hFFFE, 1'b0, -1, 100);
    checks++;
    if (timeout != 0 || w_addr.size() != 6) begin
      errors++; $display("FAIL wrap_count: got %0d (timeout %0d) expected 6", w_addr.size(), timeout);
    end
    for (int k = 0; k < w_addr.size() && k < 6; k++) begin
      checks++;
      if (w_addr[k] !== exp_wrap[k]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h expected %h", k, w_addr[k], exp_wrap[k]);
      end
    end
    @(posedge clk); #1;
    conf = 1'b1; mode = 1'b0; taps = 4'd9; weight_num = 24'd2; ddr_st_addr = 32'h0000_9000; wb_st_addr = 16'h0010;
    @(posedge clk); #1 conf = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wb_wea !== 32'h0000_00FF || wb_addr !== 16'h0013) begin
      errors++; $display("FAIL midjob_write: got wea %h addr %h expected 000000ff 0013", wb_wea, wb_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (idle !== 1'b1 || {ddr_conf, ddr_fifo_req, done, conf_err} !== 4'b0) begin
      errors++; $display("FAIL midjob_rst_ctrl: got idle %b pulses %b expected 1 0000", idle, {ddr_conf, ddr_fifo_req, done, conf_err});
    end
    checks++;
    if (wb_wea !== '0 || wb_addr !== '0 || wb_data !== '0 || ddr_len !== '0 || ddr_st_addr_out !== '0) begin
      errors++; $display("FAIL midjob_rst_data: got wea %h addr %h len %0d expected 0", wb_wea, wb_addr, ddr_len);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_broadcast();
    test_fifo_gaps();
    test_conf_err();
    test_abort();
    test_wrap_and_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Parametrised successor to the team's weight FIFO controller. It streams convolution weights from the DDR read FIFO into the weight-buffer bank array. It issues the DDR burst request, pops 512-bit-class beats with a registered read handshake, and scatters them across bank groups. Tap count is runtime (1×1 … 3×3), and a broadcast mode fills all groups in one pass. It sits between the DDR read engine and the PE-mesh weight buffers.

## Interface
- DATA_LEN, 64, bits per bank word
- LANES, 8, banks per group (= words per DDR beat); beat width BEAT_W = DATA_LEN*LANES
- BUFFER_NUM, 32, total banks; GROUPS = BUFFER_NUM/LANES (integer, ≥1)
- ADDR_LEN, 16, bank address width
- DDR_ADDR_LEN, 32, DDR byte address width
- SINGLE_LEN, 24, length/count width
- MAX_TAPS, 9, largest taps value; TAP_W = clogb2(MAX_TAPS)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- conf  in  1  start pulse; job fields sampled this cycle
- mode  in  1  0 = sequential (groups filled in turn), 1 = broadcast (every beat to all groups)
- taps  in  TAP_W  beats per weight, 1..MAX_TAPS
- weight_num  in  SINGLE_LEN  weights per group, ≥1
- ddr_st_addr  in  DDR_ADDR_LEN  DDR source byte address
- wb_st_addr  in  ADDR_LEN  first bank address
- abort  in  1  cancel running job
- ddr_st_addr_out  out  DDR_ADDR_LEN  registered copy of ddr_st_addr
- ddr_len  out  SINGLE_LEN  burst length in bytes
- ddr_conf  out  1  one-cycle burst request pulse
- ddr_fifo_empty  in  1  DDR FIFO empty
- ddr_fifo_req  out  1  FIFO pop strobe; data valid next cycle
- ddr_fifo_data  in  BEAT_W  FIFO read data
- wb_addr  out  ADDR_LEN  bank write address
- wb_data  out  BEAT_W  bank write data, word k → lane k of each enabled group
- wb_wea  out  BUFFER_NUM  per-bank write enable
- idle  out  1  high in IDLE
- done  out  1  one-cycle pulse after final write
- conf_err  out  1  one-cycle pulse: conf rejected

## Operation
- States IDLE, RUN, DRAIN. Reset: IDLE; every output 0 except idle = 1.
- IDLE + conf, fields valid → RUN. Fields are taps∈[1,MAX_TAPS] and weight_num≠0. Same edge: latch fields; ddr_st_addr_out ← ddr_st_addr; ddr_len ← weight_num*taps*P*BEAT_W/8, truncated to SINGLE_LEN. P = 1 in broadcast, GROUPS in sequential. Next cycle ddr_conf = 1 for exactly one cycle.
- conf with invalid fields, or conf outside IDLE: conf_err pulse next cycle. No other effect; a running job continues.
- Total beats T = weight_num*taps*P. Beat index order: group g (outer), weight w, tap t (inner). Address = wb_st_addr + w*taps + t, modulo 2^ADDR_LEN. Address restarts at wb_st_addr for each group.
- ddr_fifo_req = (state==RUN) && !ddr_fifo_empty && issued<T && !abort. This is combinational from registers and inputs. issued increments on each req.
- Each req → beat captured next edge → write presented. Write fields: wb_data = beat; wb_addr per index. wb_wea = lanes [g*LANES, (g+1)*LANES) in sequential mode, all ones in broadcast. wb_wea is 0 on cycles with no captured beat.
- issued reaches T → DRAIN. After the last write cycle → IDLE, and done pulses the same cycle idle rises.
- abort in RUN/DRAIN → IDLE next edge. No further req. A beat already popped is discarded, with no write. No done pulse.
- rst mid-job: immediate return to reset values. Any FIFO contents are the DDR engine's responsibility.

## Timing
- conf at edge 0 → ddr_conf high cycle 1. The first req can also be asserted in cycle 1.
- req in cycle n → wb_wea/wb_addr/wb_data valid cycle n+1 (one-cycle write latency). Sustained throughput: one beat per cycle while FIFO non-empty.
- FIFO empty for k cycles → k bubble cycles with wb_wea = 0. The address sequence is unaffected.
- Last write in cycle m → idle = 1 and done = 1 in cycle m+1.
- Simultaneous conf and abort in IDLE: conf wins. In RUN: abort wins and conf_err pulses.

## Structure
- Package weight_loader_pkg: state enum, mode constants, clogb2 function, BEAT_W/GROUPS derivations.
- Sub-module weight_addr_gen: tap/weight/group counters with wrap and last-beat flag. It advances on the capture strobe and outputs address and group index. The top holds the FSM, handshake, DDR config and wea decode.

## Test plan
- Sequential, GROUPS=4, taps=9, weight_num=2, wb_st_addr=0x10, FIFO always full → 72 writes, addr 0x10..0x21 per group. wea 0x000000FF, 0x0000FF00, … ddr_len=4608. done at cycle 74.
- Broadcast, taps=1, weight_num=5 → 5 writes, wea=0xFFFFFFFF, addr 0x10..0x14, ddr_len=320.
- Random FIFO empty gaps → no req while empty, exactly T pops, data/address order unchanged, wea 0 in bubbles.
- taps=0, taps=10, weight_num=0 → conf_err pulse each, idle stays 1, no ddr_conf.
- abort after 7 writes → no write after the in-flight beat discard, no done, idle next cycle. A fresh conf then runs cleanly.
- wb_st_addr=0xFFFE, taps=3 → address wraps to 0x0000. Assert rst mid-job → all outputs 0 and idle=1 asynchronously.
